// File: rtl/gate_stim_gen.sv
// Stimulus pattern generator (counter / walking-one / LFSR / checkerboard) feeding a gate stage.
// Optional response signature register enabled by defining GATE_STIM_MISR_EN.
module gate_stim_gen #(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [1:0] i_mode,
    input  logic [7:0] i_len,
    input  logic       i_hold,
`ifdef GATE_STIM_MISR_EN
    input  logic [7:0] i_RESP,
    output logic [7:0] o_SIG,
`endif
    output logic [7:0] o_DATA,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [1:0] mode_q;
    logic [7:0] remaining;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    function automatic logic [7:0] first_vec(input logic [1:0] mode);
        case (mode)
            2'd0:    return 8'h00;
            2'd1:    return 8'h01;
            2'd2:    return SEED_EFF;
            default: return 8'hAA;
        endcase
    endfunction

    // The last emitted vector doubles as the pattern state, so a hold freezes both at once.
    function automatic logic [7:0] next_vec(input logic [1:0] mode, input logic [7:0] cur);
        case (mode)
            2'd0:    return cur + 8'd1;
            2'd1:    return {cur[6:0], cur[7]};
            2'd2:    return lfsr_step(cur);
            default: return ~cur;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            mode_q    <= 2'd0;
            remaining <= 8'd0;
            o_DATA    <= 8'h00;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done  <= 1'b0;
                    o_valid <= 1'b0;
                    if (i_start) begin
                        // A length of 0 wraps to 255 remaining, giving 256 vectors in total.
                        state     <= RUN;
                        mode_q    <= i_mode;
                        remaining <= i_len - 8'd1;
                        o_DATA    <= first_vec(i_mode);
                        o_valid   <= 1'b1;
                        o_busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (remaining == 8'd0) begin
                        state   <= DONE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                    end else if (i_hold) begin
                        o_valid <= 1'b0;
                    end else begin
                        o_DATA    <= next_vec(mode_q, o_DATA);
                        o_valid   <= 1'b1;
                        remaining <= remaining - 8'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_STIM_MISR_EN
    // Signature absorbs the gate response for every valid vector; o_valid is low from DONE on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_SIG <= 8'h00;
        end else if (state == IDLE && i_start) begin
            o_SIG <= 8'h00;
        end else if (o_valid) begin
            o_SIG <= lfsr_step(o_SIG) ^ i_RESP;
        end
    end
`endif

endmodule

// File: tb/tb_gate_stim_gen.sv
// Randomized self-checking bench for gate_stim_gen against a sequence-level reference model.
// Define GATE_STIM_MISR_EN to also check the response signature.
module tb_gate_stim_gen;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic [7:0] i_len = 8'd0;
    logic       i_hold = 1'b0;
    logic [7:0] o_DATA;
    logic       o_valid;
    logic       o_busy;
    logic       o_done;
`ifdef GATE_STIM_MISR_EN
    logic [7:0] i_RESP;
    logic [7:0] o_SIG;
    assign i_RESP = o_DATA;
`endif

    int tests = 0;
    int fails = 0;

    gate_stim_gen dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_mode  (i_mode),
        .i_len   (i_len),
        .i_hold  (i_hold),
`ifdef GATE_STIM_MISR_EN
        .i_RESP  (i_RESP),
        .o_SIG   (o_SIG),
`endif
        .o_DATA  (o_DATA),
        .o_valid (o_valid),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] spec_lfsr(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

    // k-th vector of a sequence, computed directly from the pattern definitions.
    function automatic logic [7:0] exp_vec(input logic [1:0] mode, input int k);
        logic [7:0] v;
        case (mode)
            2'd0: v = 8'(k % 256);
            2'd1: v = 8'h01 << (k % 8);
            2'd2: begin
                v = 8'hA5;
                for (int i = 0; i < k; i++) v = spec_lfsr(v);
            end
            default: v = (k % 2 == 0) ? 8'hAA : 8'h55;
        endcase
        return v;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // hold_kind: 0 none, 1 random, 2 two-cycle stall before the 4th vector.
    // abort_after: reset once that many vectors have appeared (-1 never).
    task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] len,
                                 input int hold_kind, input int abort_after);
        int n;
        int idx;
        int held;
        int cycles;
        bit h;
        logic [7:0] vecs[$];
        n = (len == 8'd0) ? 256 : int'(len);
        for (int k = 0; k < n; k++) vecs.push_back(exp_vec(mode, k));
        held = 0;
        cycles = 0;

        i_mode  = mode;
        i_len   = len;
        i_start = 1'b1;
        i_hold  = 1'b0;
        step();
        checkOutput("first_valid", o_valid, 1);
        checkOutput("first_data", o_DATA, vecs[0]);
        checkOutput("first_busy", o_busy, 1);
        checkOutput("first_done", o_done, 0);
        idx = 1;

        while (idx < n && cycles < 3000) begin
            if (abort_after >= 0 && idx == abort_after) begin
                i_rst   = 1'b1;
                i_start = 1'b1;
                i_hold  = 1'($urandom % 2);
                step();
                checkOutput("rst_valid", o_valid, 0);
                checkOutput("rst_data", o_DATA, 8'h00);
                checkOutput("rst_busy", o_busy, 0);
                checkOutput("rst_done", o_done, 0);
                i_rst   = 1'b0;
                i_start = 1'b0;
                i_hold  = 1'b0;
                step();
                checkOutput("post_rst_done", o_done, 0);
                checkOutput("post_rst_valid", o_valid, 0);
                return;
            end
            case (hold_kind)
                1:       h = ($urandom_range(0, 3) == 0);
                2:       h = (idx == 3 && held < 2);
                default: h = 1'b0;
            endcase
            if (h) held++;
            i_hold  = h;
            i_start = 1'($urandom % 2);
            i_mode  = 2'($urandom);
            i_len   = 8'($urandom);
            step();
            cycles++;
            checkOutput("run_busy", o_busy, 1);
            checkOutput("run_done", o_done, 0);
            if (h) begin
                checkOutput("hold_valid", o_valid, 0);
                checkOutput("hold_data", o_DATA, vecs[idx-1]);
            end else begin
                checkOutput("vec_valid", o_valid, 1);
                checkOutput("vec_data", o_DATA, vecs[idx]);
                idx++;
            end
        end
        if (idx < n) checkOutput("seq_timeout", 0, 1);

        i_hold  = 1'($urandom % 2);
        i_start = 1'($urandom % 2);
        step();
        checkOutput("done_pulse", o_done, 1);
        checkOutput("done_busy", o_busy, 0);
        checkOutput("done_valid", o_valid, 0);
        checkOutput("done_data", o_DATA, vecs[n-1]);
`ifdef GATE_STIM_MISR_EN
        begin
            logic [7:0] sig;
            sig = 8'h00;
            foreach (vecs[k]) sig = spec_lfsr(sig) ^ vecs[k];
            checkOutput("misr_sig", o_SIG, sig);
        end
`endif
        i_start = 1'b0;
        i_hold  = 1'b0;
        step();
        checkOutput("idle_done", o_done, 0);
        checkOutput("idle_busy", o_busy, 0);
        checkOutput("idle_valid", o_valid, 0);
        checkOutput("idle_data", o_DATA, vecs[n-1]);
    endtask

    initial begin
        step();
        step();
        checkOutput("reset_data", o_DATA, 8'h00);
        checkOutput("reset_valid", o_valid, 0);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_done", o_done, 0);
        i_rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checkOutput("idle_no_valid", o_valid, 0);

        applyStimulus(2'd0, 8'd4, 0, -1);
        applyStimulus(2'd2, 8'd3, 0, -1);
        applyStimulus(2'd1, 8'd10, 2, -1);
        applyStimulus(2'd3, 8'd0, 0, -1);
        applyStimulus(2'd0, 8'd8, 0, 2);
        applyStimulus(2'd0, 8'd8, 0, -1);
`ifdef GATE_STIM_MISR_EN
        applyStimulus(2'd0, 8'd2, 0, -1);
`endif

        for (int r = 0; r < 25; r++) begin
            logic [7:0] len;
            len = ($urandom % 2 == 0) ? 8'($urandom_range(1, 12)) : 8'($urandom);
            applyStimulus(2'($urandom), len, 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
